// File: rtl/fight_pkg.sv
// Shared fight definitions: attack codes, sequencer phase encodings and game-state values.
// Used by attack_sequencer and by HealthManagement.
package fight_pkg;

    localparam logic [1:0] ATK_NONE  = 2'b00;
    localparam logic [1:0] ATK_LIGHT = 2'b01;
    localparam logic [1:0] ATK_HEAVY = 2'b10;

    localparam logic [1:0] GS_FIGHT  = 2'b00;

    localparam int CNT_W = 6;

    typedef enum logic [2:0] {
        PH_IDLE     = 3'd0,
        PH_STARTUP  = 3'd1,
        PH_ACTIVE   = 3'd2,
        PH_RECOVERY = 3'd3,
        PH_STUN     = 3'd4
    } phase_t;

    // Terminal count for a phase of n frames; a zero-length phase still lasts one frame.
    function automatic logic [CNT_W-1:0] last_count(input int unsigned n);
        return (n == 0) ? '0 : CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer for an asynchronous button plus a one-clock rising-edge pulse.
module btn_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= btn;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;

endmodule

// File: rtl/attack_sequencer.sv
// Per-player attack sequencer: button edges -> startup/active/recovery phases counted in frames,
// with a single attack_state pulse per landed attack. Define ATTACK_BUFFER_EN for a one-deep press buffer.
module attack_sequencer
    import fight_pkg::*;
#(
    parameter int unsigned LIGHT_STARTUP  = 2,
    parameter int unsigned LIGHT_ACTIVE   = 3,
    parameter int unsigned LIGHT_RECOVERY = 4,
    parameter int unsigned HEAVY_STARTUP  = 5,
    parameter int unsigned HEAVY_ACTIVE   = 4,
    parameter int unsigned HEAVY_RECOVERY = 10,
    parameter int unsigned STUN_FRAMES    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       btn_light,
    input  logic       btn_heavy,
    input  logic       hit_range,
    input  logic       got_hit,
    input  logic [1:0] game_state,
    output logic [1:0] attack_state,
    output logic [2:0] phase,
    output logic       busy
);

    logic light_rise;
    logic heavy_rise;

    btn_edge_sync u_light_sync (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_light),
        .rise  (light_rise)
    );

    btn_edge_sync u_heavy_sync (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_heavy),
        .rise  (heavy_rise)
    );

    phase_t           phase_q,  phase_n;
    logic [CNT_W-1:0] cnt_q,    cnt_n;
    logic [CNT_W-1:0] last_cnt;
    logic [1:0]       kind_q,   kind_n;
    logic [1:0]       atk_q,    atk_n;
    logic             landed_q, landed_n;
`ifdef ATTACK_BUFFER_EN
    logic [1:0]       pend_q,   pend_n;
`endif

    always_comb begin
        last_cnt = '0;
        case (phase_q)
            PH_STARTUP:  last_cnt = (kind_q == ATK_HEAVY) ? last_count(HEAVY_STARTUP)
                                                          : last_count(LIGHT_STARTUP);
            PH_ACTIVE:   last_cnt = (kind_q == ATK_HEAVY) ? last_count(HEAVY_ACTIVE)
                                                          : last_count(LIGHT_ACTIVE);
            PH_RECOVERY: last_cnt = (kind_q == ATK_HEAVY) ? last_count(HEAVY_RECOVERY)
                                                          : last_count(LIGHT_RECOVERY);
            PH_STUN:     last_cnt = last_count(STUN_FRAMES);
            default:     last_cnt = '0;
        endcase
    end

    always_comb begin
        phase_n  = phase_q;
        cnt_n    = cnt_q;
        kind_n   = kind_q;
        landed_n = landed_q;
        atk_n    = ATK_NONE;
`ifdef ATTACK_BUFFER_EN
        pend_n   = pend_q;
`endif
        if (game_state != GS_FIGHT) begin
            phase_n  = PH_IDLE;
            cnt_n    = '0;
            kind_n   = ATK_NONE;
            landed_n = 1'b0;
`ifdef ATTACK_BUFFER_EN
            pend_n   = ATK_NONE;
`endif
        end else if (got_hit) begin
            // Entering (or re-entering) STUN restarts the count and drops any due pulse.
            phase_n  = PH_STUN;
            cnt_n    = '0;
            kind_n   = ATK_NONE;
            landed_n = 1'b0;
`ifdef ATTACK_BUFFER_EN
            pend_n   = ATK_NONE;
`endif
        end else begin
            if (phase_q == PH_ACTIVE && hit_range && !landed_q) begin
                atk_n    = kind_q;
                landed_n = 1'b1;
            end
`ifdef ATTACK_BUFFER_EN
            if (phase_q == PH_RECOVERY) begin
                if (heavy_rise)
                    pend_n = ATK_HEAVY;
                else if (light_rise && pend_q != ATK_HEAVY)
                    pend_n = ATK_LIGHT;
            end
`endif
            case (phase_q)
                PH_IDLE: begin
                    if (heavy_rise || light_rise) begin
                        phase_n  = PH_STARTUP;
                        cnt_n    = '0;
                        kind_n   = heavy_rise ? ATK_HEAVY : ATK_LIGHT;
                        landed_n = 1'b0;
                    end
                end
                default: begin
                    if (frame_tick) begin
                        if (cnt_q == last_cnt) begin
                            cnt_n = '0;
                            case (phase_q)
                                PH_STARTUP:  phase_n = PH_ACTIVE;
                                PH_ACTIVE:   phase_n = PH_RECOVERY;
                                PH_RECOVERY: begin
                                    phase_n = PH_IDLE;
                                    kind_n  = ATK_NONE;
`ifdef ATTACK_BUFFER_EN
                                    if (pend_n != ATK_NONE) begin
                                        phase_n  = PH_STARTUP;
                                        kind_n   = pend_n;
                                        landed_n = 1'b0;
                                        pend_n   = ATK_NONE;
                                    end
`endif
                                end
                                default:     phase_n = PH_IDLE;
                            endcase
                        end else begin
                            cnt_n = cnt_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q  <= PH_IDLE;
            cnt_q    <= '0;
            kind_q   <= ATK_NONE;
            atk_q    <= ATK_NONE;
            landed_q <= 1'b0;
`ifdef ATTACK_BUFFER_EN
            pend_q   <= ATK_NONE;
`endif
        end else begin
            phase_q  <= phase_n;
            cnt_q    <= cnt_n;
            kind_q   <= kind_n;
            atk_q    <= atk_n;
            landed_q <= landed_n;
`ifdef ATTACK_BUFFER_EN
            pend_q   <= pend_n;
`endif
        end
    end

    assign attack_state = atk_q;
    assign phase        = phase_q;
    assign busy         = (phase_q != PH_IDLE);

endmodule

// File: tb/tb_attack_sequencer.sv
// Bench for attack_sequencer: directed scenarios plus random stimulus, checked every clock
// against a frame-countdown reference model with a button delay line.
module tb_attack_sequencer;
    import fight_pkg::*;

    localparam int L_SU = 2, L_AC = 3, L_RE = 4;
    localparam int H_SU = 5, H_AC = 4, H_RE = 10;
    localparam int STUN_N = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       btn_light;
    logic       btn_heavy;
    logic       hit_range;
    logic       got_hit;
    logic [1:0] game_state;
    logic [1:0] attack_state;
    logic [2:0] phase;
    logic       busy;

    always #5 clk = ~clk;

    attack_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .btn_light    (btn_light),
        .btn_heavy    (btn_heavy),
        .hit_range    (hit_range),
        .got_hit      (got_hit),
        .game_state   (game_state),
        .attack_state (attack_state),
        .phase        (phase),
        .busy         (busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: frames remaining per phase, button history as a sample delay line.
    int m_phase, m_left, m_kind, m_pend, m_atk;
    bit m_landed;
    bit hl[4];
    bit hh[4];

    function automatic int dur(input int ph, input int kind);
        int d;
        d = 1;
        case (ph)
            PH_STARTUP:  d = (kind == ATK_HEAVY) ? H_SU : L_SU;
            PH_ACTIVE:   d = (kind == ATK_HEAVY) ? H_AC : L_AC;
            PH_RECOVERY: d = (kind == ATK_HEAVY) ? H_RE : L_RE;
            PH_STUN:     d = STUN_N;
            default:     d = 1;
        endcase
        return (d == 0) ? 1 : d;
    endfunction

    task automatic model_reset();
        m_phase = PH_IDLE; m_left = 0; m_kind = ATK_NONE; m_pend = ATK_NONE;
        m_atk = ATK_NONE; m_landed = 0;
        for (int i = 0; i < 4; i++) begin hl[i] = 0; hh[i] = 0; end
    endtask

    task automatic model_start(input int k);
        m_phase = PH_STARTUP; m_kind = k; m_landed = 0; m_left = dur(PH_STARTUP, k);
    endtask

    task automatic model_clock();
        bit le, he;
        int old;
        for (int i = 3; i > 0; i--) begin hl[i] = hl[i-1]; hh[i] = hh[i-1]; end
        hl[0] = btn_light; hh[0] = btn_heavy;
        le = hl[2] & ~hl[3];
        he = hh[2] & ~hh[3];
        old = m_phase;
        m_atk = ATK_NONE;
        if (game_state != 2'b00) begin
            m_phase = PH_IDLE; m_kind = ATK_NONE; m_landed = 0; m_pend = ATK_NONE;
        end else if (got_hit) begin
            m_phase = PH_STUN; m_left = dur(PH_STUN, 0); m_kind = ATK_NONE;
            m_landed = 0; m_pend = ATK_NONE;
        end else begin
            if (old == PH_ACTIVE && hit_range && !m_landed) begin
                m_atk = m_kind; m_landed = 1;
            end
`ifdef ATTACK_BUFFER_EN
            if (old == PH_RECOVERY) begin
                if (he) m_pend = ATK_HEAVY;
                else if (le && m_pend != ATK_HEAVY) m_pend = ATK_LIGHT;
            end
`endif
            if (old == PH_IDLE) begin
                if (he) model_start(ATK_HEAVY);
                else if (le) model_start(ATK_LIGHT);
            end else if (frame_tick) begin
                m_left--;
                if (m_left == 0) begin
                    if (old == PH_STARTUP) begin
                        m_phase = PH_ACTIVE; m_left = dur(PH_ACTIVE, m_kind);
                    end else if (old == PH_ACTIVE) begin
                        m_phase = PH_RECOVERY; m_left = dur(PH_RECOVERY, m_kind);
                    end else if (old == PH_RECOVERY) begin
                        m_phase = PH_IDLE; m_kind = ATK_NONE;
`ifdef ATTACK_BUFFER_EN
                        if (m_pend != ATK_NONE) begin
                            model_start(m_pend);
                            m_pend = ATK_NONE;
                        end
`endif
                    end else begin
                        m_phase = PH_IDLE;
                    end
                end
            end
        end
    endtask

    int tick_period = 0;
    int cyc = 0;
    int busy_ticks, ticks_since, pulses, active_cyc, pulse_cyc;
    logic [1:0] last_pulse;

    task automatic step();
        logic pb;
        logic [2:0] pp;
        if (tick_period > 0) frame_tick = ((cyc % tick_period) == (tick_period - 1));
        pb = busy;
        pp = phase;
        @(posedge clk);
        model_clock();
        #1;
        cyc++;
        if (frame_tick && pb) busy_ticks++;
        if (frame_tick) ticks_since++;
        if (phase == PH_ACTIVE && pp != PH_ACTIVE) active_cyc = cyc;
        if (attack_state != 2'b00) begin
            pulses++; last_pulse = attack_state; pulse_cyc = cyc;
        end
        chk("phase", 32'(phase), 32'(m_phase));
        chk("attack_state", 32'(attack_state), 32'(m_atk));
        chk("busy", 32'(busy), 32'(m_phase != PH_IDLE));
    endtask

    task automatic wait_phase(input string tag, input logic [2:0] target, input int budget);
        for (int i = 0; i < budget && phase != target; i++) step();
        chk(tag, 32'(phase), 32'(target));
    endtask

    task automatic press(input bit l, input bit h);
        btn_light = l; btn_heavy = h;
        step(); step();
        btn_light = 0; btn_heavy = 0;
    endtask

    task automatic clear_stats();
        busy_ticks = 0; ticks_since = 0; pulses = 0;
        active_cyc = -100; pulse_cyc = 0; last_pulse = 2'b00;
    endtask

    initial begin
        int busy_seen;
        reset = 1'b0; frame_tick = 0; btn_light = 0; btn_heavy = 0;
        hit_range = 0; got_hit = 0; game_state = 2'b00;
        model_reset();
        clear_stats();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_phase", 32'(phase), 32'(PH_IDLE));
        chk("reset_attack", 32'(attack_state), 32'(ATK_NONE));
        chk("reset_busy", 32'(busy), 32'd0);
        @(negedge clk) reset = 1'b1;
        repeat (3) step();

        // Light attack with contact held through the whole active window.
        tick_period = 10; cyc = 0; hit_range = 1; clear_stats();
        press(1, 0);
        wait_phase("t1_startup", PH_STARTUP, 5);
        wait_phase("t1_idle", PH_IDLE, 300);
        chk("t1_pulses", 32'(pulses), 32'd1);
        chk("t1_kind", 32'(last_pulse), 32'(ATK_LIGHT));
        chk("t1_pulse_lag", 32'(pulse_cyc - active_cyc), 32'd1);
        chk("t1_busy_ticks", 32'(busy_ticks), 32'(L_SU + L_AC + L_RE));

        // Simultaneous light and heavy press: heavy wins.
        repeat (5) step();
        clear_stats();
        press(1, 1);
        wait_phase("t2_startup", PH_STARTUP, 5);
        wait_phase("t2_idle", PH_IDLE, 400);
        chk("t2_pulses", 32'(pulses), 32'd1);
        chk("t2_kind", 32'(last_pulse), 32'(ATK_HEAVY));
        chk("t2_busy_ticks", 32'(busy_ticks), 32'(H_SU + H_AC + H_RE));

        // Hit during heavy active before contact, then a re-hit inside stun.
        hit_range = 0; clear_stats();
        press(0, 1);
        wait_phase("t3_active", PH_ACTIVE, 200);
        step();
        hit_range = 1; got_hit = 1;
        step();
        got_hit = 0; ticks_since = 0;
        chk("t3_stun", 32'(phase), 32'(PH_STUN));
        wait_phase("t3_idle", PH_IDLE, 300);
        chk("t3_stun_ticks", 32'(ticks_since), 32'(STUN_N));
        chk("t3_no_pulse", 32'(pulses), 32'd0);
        hit_range = 0;
        got_hit = 1; step(); got_hit = 0; ticks_since = 0;
        for (int i = 0; i < 200 && ticks_since < 5; i++) step();
        chk("t3_mid_stun", 32'(phase), 32'(PH_STUN));
        got_hit = 1; step(); got_hit = 0; ticks_since = 0;
        wait_phase("t3_idle2", PH_IDLE, 300);
        chk("t3_restart_ticks", 32'(ticks_since), 32'(STUN_N));

        // Round ends mid-startup; buttons ignored until fighting resumes.
        press(1, 0);
        wait_phase("t4_startup", PH_STARTUP, 5);
        game_state = 2'b01;
        step();
        chk("t4_forced_idle", 32'(phase), 32'(PH_IDLE));
        chk("t4_no_attack", 32'(attack_state), 32'(ATK_NONE));
        busy_seen = 0;
        press(0, 1);
        for (int i = 0; i < 30; i++) begin
            step();
            if (busy) busy_seen++;
        end
        chk("t4_ignored", 32'(busy_seen), 32'd0);
        game_state = 2'b00;
        repeat (5) step();
        press(1, 0);
        wait_phase("t4_resume", PH_STARTUP, 5);
        wait_phase("t4_idle", PH_IDLE, 300);

        // Light press during recovery.
        press(1, 0);
        wait_phase("t5_recovery", PH_RECOVERY, 300);
        step(); step();
        press(1, 0);
        for (int i = 0; i < 100 && phase == PH_RECOVERY; i++) step();
`ifdef ATTACK_BUFFER_EN
        chk("t5_after_recovery", 32'(phase), 32'(PH_STARTUP));
`else
        chk("t5_after_recovery", 32'(phase), 32'(PH_IDLE));
        repeat (20) step();
        chk("t5_stays_idle", 32'(phase), 32'(PH_IDLE));
`endif
        wait_phase("t5_idle", PH_IDLE, 300);

        // Reset asserted while a contact pulse is due.
        hit_range = 1; clear_stats();
        press(1, 0);
        wait_phase("t6_active", PH_ACTIVE, 200);
        #2 reset = 1'b0;
        #1;
        chk("t6_phase", 32'(phase), 32'(PH_IDLE));
        chk("t6_attack", 32'(attack_state), 32'(ATK_NONE));
        chk("t6_busy", 32'(busy), 32'd0);
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        pulses = 0;
        repeat (40) step();
        chk("t6_no_pulse", 32'(pulses), 32'd0);

        // Random traffic against the model.
        tick_period = 0;
        for (int i = 0; i < 2000; i++) begin
            frame_tick = ($urandom_range(0, 3) == 0);
            btn_light  = ($urandom_range(0, 5) == 0);
            btn_heavy  = ($urandom_range(0, 9) == 0);
            hit_range  = $urandom_range(0, 1) != 0;
            got_hit    = ($urandom_range(0, 79) == 0);
            game_state = ($urandom_range(0, 199) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
